input_debounce: RTL and testbench
=================================

Name: input_debounce

Overview:
Debounce and edge-detect stage for one push-button or switch channel. It sits directly downstream of the two-flop input synchronizer and consumes only its already-synchronized output. It produces a clean debounced level, single-cycle press and release pulses, and an optional auto-repeat pulse train while the button is held. These outputs feed the game-control FSM. One instance is used per physical input.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive identical samples required to accept a level change (1 ms at 50 MHz); legal range >= 2
REPEAT_DELAY, 25000000, cycles held after press before the first repeat pulse; 0 disables auto-repeat
REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses; legal range >= 1
CNT_W, $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1), counter width; derived, never overridden

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_sync  in  1  synchronized raw button level, 1 = pressed
level  out  1  debounced button level
press  out  1  one-cycle pulse when level rises
release  out  1  one-cycle pulse when level falls
repeat_p  out  1  one-cycle auto-repeat pulse while held

Behaviour:
- Interface: clock clk; reset is synchronous, active-high.
- All outputs are registered.
- Reset values: level=0, press=0, release=0, repeat_p=0, state=S_RELEASED, all counters 0.
- A reset asserted mid-operation wins on that edge: the block returns to the reset state and emits no pulse.
- FSM states: S_RELEASED, S_PRESS_CHK, S_PRESSED, S_RELEASE_CHK.
- S_RELEASED: if in_sync=1, go to S_PRESS_CHK with deb_cnt=1; otherwise stay.
- S_PRESS_CHK, in_sync=0: return to S_RELEASED, deb_cnt=0, no pulse.
- S_PRESS_CHK, in_sync=1 and deb_cnt==DEBOUNCE_CYCLES-1: go to S_PRESSED, level<=1, press<=1, rpt_cnt<=0.
- S_PRESS_CHK, in_sync=1 otherwise: deb_cnt++.
- Press latency: level and press rise on the edge that samples the DEBOUNCE_CYCLES-th consecutive high in_sync, so press is visible exactly DEBOUNCE_CYCLES cycles after in_sync rises.
- S_PRESSED: if in_sync=0, go to S_RELEASE_CHK with deb_cnt=1. The repeat counter freezes; it does not reset.
- S_RELEASE_CHK: symmetric to S_PRESS_CHK. A return to in_sync=1 goes back to S_PRESSED with the repeat counter resumed. Acceptance drives level<=0 and release<=1.
- press, release and repeat_p are high for exactly one cycle. press and release are never asserted in the same cycle.
- Auto-repeat, only when REPEAT_DELAY>0 and in S_PRESSED: rpt_cnt increments each cycle.
- First repeat: when rpt_cnt reaches REPEAT_DELAY, repeat_p pulses and rpt_cnt loads REPEAT_DELAY-REPEAT_PERIOD+1. Each subsequent repeat_p is therefore REPEAT_PERIOD cycles apart.
- repeat_p is never asserted in the same cycle as press.
- Counter rules: deb_cnt saturates and never wraps. rpt_cnt is reloaded before it can overflow CNT_W.
- Glitch rule: a single-cycle in_sync glitch of any length shorter than DEBOUNCE_CYCLES produces no change on any output.

Decomposition:
- Shared package input_pkg holds:
  - typedef enum logic [1:0] deb_state_t for the four states;
  - default constants CLK_HZ=50_000_000, DEBOUNCE_MS=1, and the derived DEFAULT_DEBOUNCE_CYCLES.
- No sub-module is required. The two counters and the FSM are a single ~200-line module.
- The multi-button top instantiates synchronizer + input_debounce per channel in a generate loop. That top is not part of this block.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
1. Reset: hold reset 3 cycles with in_sync=1 -> all outputs 0; after release, press fires 4 cycles later, not earlier.
2. Clean press/release: in_sync 0->1 at cycle 10, 1->0 at cycle 30 -> press and level rise at cycle 14 (press 1 cycle wide); release at cycle 34, level=0 from cycle 34.
3. Bounce: in_sync pattern 1,1,1,0,1,1,1,1 starting cycle 5 -> no pulse on the first burst; press exactly 4 cycles after the final rising edge; exactly one press total.
4. Auto-repeat: hold in_sync=1 for 40 cycles -> press at t, repeat_p at t+10, t+15, t+20, ... all 1 cycle wide; none after release is accepted.
5. Release glitch: while pressed, in_sync=0 for 2 cycles then 1 -> level stays 1, no release pulse, and the repeat spacing is preserved (shifted by the 2 frozen cycles).
6. Reset mid-check: assert reset during S_PRESS_CHK at deb_cnt=3 -> no press pulse; the next accepted press needs a full 4 fresh samples.

Source files
------------

// File: rtl/input_pkg.sv
// Shared state encoding and default timing constants for the button
// debounce channels.
package input_pkg;

   typedef enum logic [1:0] {
      S_RELEASED    = 2'd0,
      S_PRESS_CHK   = 2'd1,
      S_PRESSED     = 2'd2,
      S_RELEASE_CHK = 2'd3
   } deb_state_t;

   localparam int CLK_HZ                  = 50_000_000;
   localparam int DEBOUNCE_MS             = 1;
   localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/input_debounce.sv
// Debounce, edge detect and auto-repeat for one synchronized button input.
// The release pulse is named release_p because "release" is a reserved word.
module input_debounce
   import input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic in_sync,
   output logic level,
   output logic press,
   output logic release_p,
   output logic repeat_p
);

   localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_ALL = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
   localparam int CNT_W   = $clog2(MAX_ALL + 1);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_MAX   = '1;
   localparam logic [CNT_W:0]   RPT_FIRST = (CNT_W+1)'(REPEAT_DELAY);
   localparam logic [CNT_W:0]   RPT_NEXT  = (CNT_W+1)'(REPEAT_PERIOD);
   localparam bit               RPT_EN    = (REPEAT_DELAY > 0);

   deb_state_t       state, state_nxt;
   logic [CNT_W-1:0] deb_cnt, deb_nxt;
   logic [CNT_W-1:0] rpt_cnt, rpt_nxt;
   logic             rpt_armed, armed_nxt;
   logic             level_nxt, press_nxt, release_nxt, repeat_nxt;
   logic             hold;
   logic [CNT_W:0]   rpt_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == DEB_MAX) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_RELEASED;
         deb_cnt   <= '0;
         rpt_cnt   <= '0;
         rpt_armed <= 1'b0;
         level     <= 1'b0;
         press     <= 1'b0;
         release_p <= 1'b0;
         repeat_p  <= 1'b0;
      end else begin
         state     <= state_nxt;
         deb_cnt   <= deb_nxt;
         rpt_cnt   <= rpt_nxt;
         rpt_armed <= armed_nxt;
         level     <= level_nxt;
         press     <= press_nxt;
         release_p <= release_nxt;
         repeat_p  <= repeat_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      deb_nxt     = deb_cnt;
      rpt_nxt     = rpt_cnt;
      armed_nxt   = rpt_armed;
      level_nxt   = level;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      repeat_nxt  = 1'b0;
      hold        = 1'b0;
      rpt_inc     = '0;

      case (state)
         S_RELEASED: begin
            if (in_sync) begin
               state_nxt = S_PRESS_CHK;
               deb_nxt   = DEB_ONE;
            end
         end
         S_PRESS_CHK: begin
            if (!in_sync) begin
               state_nxt = S_RELEASED;
               deb_nxt   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = S_PRESSED;
               deb_nxt   = '0;
               level_nxt = 1'b1;
               press_nxt = 1'b1;
               rpt_nxt   = '0;
               armed_nxt = 1'b0;
            end else begin
               deb_nxt = sat_inc(deb_cnt);
            end
         end
         S_PRESSED: begin
            if (!in_sync) begin
               state_nxt = S_RELEASE_CHK;
               deb_nxt   = DEB_ONE;
            end else begin
               hold = 1'b1;
            end
         end
         S_RELEASE_CHK: begin
            // A bounce back to high resumes the repeat count on this same edge,
            // so the repeat train shifts only by the number of low samples.
            if (in_sync) begin
               state_nxt = S_PRESSED;
               deb_nxt   = '0;
               hold      = 1'b1;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt   = S_RELEASED;
               deb_nxt     = '0;
               level_nxt   = 1'b0;
               release_nxt = 1'b1;
            end else begin
               deb_nxt = sat_inc(deb_cnt);
            end
         end
         default: state_nxt = S_RELEASED;
      endcase

      // rpt_cnt counts held cycles since press or since the last repeat pulse;
      // the first interval is REPEAT_DELAY, later ones REPEAT_PERIOD.
      if (RPT_EN && hold) begin
         rpt_inc = {1'b0, rpt_cnt} + 1'b1;
         if (rpt_inc == (rpt_armed ? RPT_NEXT : RPT_FIRST)) begin
            repeat_nxt = 1'b1;
            rpt_nxt    = '0;
            armed_nxt  = 1'b1;
         end else begin
            rpt_nxt = rpt_inc[CNT_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5; pulses are logged by cycle number and compared to hand values.
module tb_input_debounce;

   logic clk = 1'b0;
   logic reset;
   logic in_sync;
   logic level;
   logic press;
   logic release_p;
   logic repeat_p;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;
   int press_q[$];
   int rel_q[$];
   int rep_q[$];
   int exp_q[$];

   input_debounce #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_sync  (in_sync),
      .level    (level),
      .press    (press),
      .release_p(release_p),
      .repeat_p (repeat_p)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (press === 1'b1)     press_q.push_back(cyc);
      if (release_p === 1'b1) rel_q.push_back(cyc);
      if (repeat_p === 1'b1)  rep_q.push_back(cyc);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic check_q(input string tag, input int got[$], input int want[$]);
      check({tag, ".count"}, got.size(), want.size());
      for (int i = 0; i < want.size(); i++)
         check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, want[i]);
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      press_q.delete();
      rel_q.delete();
      rep_q.delete();
   endtask

   initial begin
      // reset held with the button already down
      reset   = 1'b1;
      in_sync = 1'b1;
      goto(3);
      check("rst.level", level, 0);
      check("rst.press", press, 0);
      check("rst.release", release_p, 0);
      check("rst.repeat", repeat_p, 0);
      reset = 1'b0;
      goto(6);
      check("rst.early_press", press, 0);
      goto(7);
      check("rst.press_at_7", press, 1);
      check("rst.level_at_7", level, 1);
      goto(8);
      check("rst.press_width", press, 0);
      in_sync = 1'b0;
      goto(18);
      exp_q = {7};  check_q("rst.press_log", press_q, exp_q);
      exp_q = {12}; check_q("rst.rel_log", rel_q, exp_q);
      check("rst.rep_none", rep_q.size(), 0);
      clear_logs();

      // clean press and release, held long enough for two repeats
      goto(20); in_sync = 1'b1;
      goto(23); check("clean.level_pre", level, 0);
      goto(24); check("clean.press", press, 1); check("clean.level", level, 1);
      goto(25); check("clean.press_width", press, 0);
      goto(40); in_sync = 1'b0;
      goto(43); check("clean.level_hold", level, 1);
      goto(44); check("clean.release", release_p, 1); check("clean.level_low", level, 0);
      goto(45); check("clean.release_width", release_p, 0);
      goto(55);
      exp_q = {24};     check_q("clean.press_log", press_q, exp_q);
      exp_q = {44};     check_q("clean.rel_log", rel_q, exp_q);
      exp_q = {34, 39}; check_q("clean.rep_log", rep_q, exp_q);
      clear_logs();

      // bounce: 1,1,1,0 then steady 1
      goto(60); in_sync = 1'b1;
      goto(63); in_sync = 1'b0;
      goto(64); in_sync = 1'b1;
      goto(67); check("bounce.level_pre", level, 0);
      goto(70); in_sync = 1'b0;
      goto(85);
      exp_q = {68}; check_q("bounce.press_log", press_q, exp_q);
      exp_q = {74}; check_q("bounce.rel_log", rel_q, exp_q);
      check("bounce.rep_none", rep_q.size(), 0);
      clear_logs();

      // auto-repeat over a 40-cycle hold
      goto(100); in_sync = 1'b1;
      goto(140); in_sync = 1'b0;
      goto(143); check("rpt.level_hold", level, 1);
      goto(144); check("rpt.level_low", level, 0);
      goto(170);
      exp_q = {104};                          check_q("rpt.press_log", press_q, exp_q);
      exp_q = {114, 119, 124, 129, 134, 139}; check_q("rpt.rep_log", rep_q, exp_q);
      exp_q = {144};                          check_q("rpt.rel_log", rel_q, exp_q);
      clear_logs();

      // two-cycle release glitch while held
      goto(200); in_sync = 1'b1;
      goto(210); in_sync = 1'b0;
      goto(212); in_sync = 1'b1; check("glitch.level_mid", level, 1);
      goto(214); check("glitch.level_after", level, 1);
      goto(230); in_sync = 1'b0;
      goto(250);
      exp_q = {204};           check_q("glitch.press_log", press_q, exp_q);
      exp_q = {216, 221, 226}; check_q("glitch.rep_log", rep_q, exp_q);
      exp_q = {234};           check_q("glitch.rel_log", rel_q, exp_q);
      clear_logs();

      // reset during the press check with three highs already counted
      goto(300); in_sync = 1'b1;
      goto(303); reset = 1'b1;
      goto(304); reset = 1'b0;
      check("midrst.press", press, 0);
      check("midrst.level", level, 0);
      goto(307); check("midrst.early_press", press, 0);
      goto(308); check("midrst.press_at_308", press, 1);
      goto(310); in_sync = 1'b0;
      goto(325);
      exp_q = {308}; check_q("midrst.press_log", press_q, exp_q);
      exp_q = {314}; check_q("midrst.rel_log", rel_q, exp_q);
      check("midrst.rep_none", rep_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
